// File: rtl/knn_ctrl.sv
// knn_ctrl: sequencer for a K-slot nearest-neighbour core.
//
// For one test point, the controller:
//   1. clears the core,
//   2. streams n_points training entries from memory into the core,
//   3. runs a majority vote over the nearest min(n_points, K) slots,
//   4. reports the winning label.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   start, n_points,  classification request; sampled only in IDLE
//   test_x, test_y
//   mem_en, mem_addr  training-memory read strobe and address
//   mem_rdata         {label, x, y}; valid one cycle after mem_en
//   core_clr, core_we core neighbour-list clear and write strobes
//   core_ax/ay        registered test point
//   core_bx/by/label  operands taken straight from mem_rdata
//   core_labels       slot labels; slot 0 (nearest) is in bits [7:0]
//   busy, done        status; done is a one-cycle pulse
//   result_label      winning label (8'hFF when n_points is 0)
//   cycle_cnt         busy-cycle counter
//
// Optional feature: define KNN_CTRL_CNT_EN to build the cycle counter.
// Otherwise cycle_cnt is tied to zero.
module knn_ctrl #(
    parameter int K   = 10,
    parameter int N_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N_W-1:0]   n_points,
    input  logic [15:0]      test_x,
    input  logic [15:0]      test_y,
    output logic             mem_en,
    output logic [N_W-1:0]   mem_addr,
    input  logic [39:0]      mem_rdata,
    output logic             core_clr,
    output logic             core_we,
    output logic [15:0]      core_ax,
    output logic [15:0]      core_ay,
    output logic [15:0]      core_bx,
    output logic [15:0]      core_by,
    output logic [7:0]       core_label,
    input  logic [8*K-1:0]   core_labels,
    output logic             busy,
    output logic             done,
    output logic [7:0]       result_label,
    output logic [31:0]      cycle_cnt
);

    localparam int M_W = $clog2(K + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_VOTE,
        S_DONE
    } state_t;

    state_t         state;
    logic [N_W-1:0] n_reg;
    logic [M_W-1:0] m_reg;
    logic [M_W-1:0] vote_idx;
    logic [M_W-1:0] best_cnt;
    logic [7:0]     best_label;

    logic [7:0]     cur_label_s;
    logic [M_W-1:0] cur_cnt_s;
    logic           cur_wins_s;

    // Write operands come straight from the memory data in the cycle after each read.
    assign core_bx    = mem_rdata[31:16];
    assign core_by    = mem_rdata[15:0];
    assign core_label = mem_rdata[39:32];

    // Vote datapath: label of the slot under test, and how many active slots share it.
    always_comb begin
        cur_label_s = 8'd0;
        cur_cnt_s   = {M_W{1'b0}};
        for (int j = 0; j < K; j++) begin
            cur_label_s = cur_label_s |
                          (core_labels[j*8 +: 8] & {8{vote_idx == M_W'(j)}});
        end
        for (int j = 0; j < K; j++) begin
            // Slots at or beyond M hold no training point and do not vote.
            cur_cnt_s = cur_cnt_s +
                        M_W'((M_W'(j) < m_reg) && (core_labels[j*8 +: 8] == cur_label_s));
        end
        // Strictly greater only, so on a tie the nearer slot keeps the lead.
        cur_wins_s = (cur_cnt_s > best_cnt);
    end

    // Main controller FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            n_reg        <= {N_W{1'b0}};
            m_reg        <= {M_W{1'b0}};
            vote_idx     <= {M_W{1'b0}};
            best_cnt     <= {M_W{1'b0}};
            best_label   <= 8'd0;
            mem_en       <= 1'b0;
            mem_addr     <= {N_W{1'b0}};
            core_clr     <= 1'b0;
            core_we      <= 1'b0;
            core_ax      <= 16'd0;
            core_ay      <= 16'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            result_label <= 8'hFF;
        end else begin
            done     <= 1'b0;
            core_clr <= 1'b0;
            // Read data lands one cycle after each stream cycle, so the write follows it.
            core_we  <= (state == S_STREAM);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (n_points != {N_W{1'b0}}) begin
                            n_reg    <= n_points;
                            core_ax  <= test_x;
                            core_ay  <= test_y;
                            m_reg    <= (n_points >= N_W'(K)) ? M_W'(K)
                                                               : n_points[M_W-1:0];
                            core_clr <= 1'b1;
                            state    <= S_CLEAR;
                        end else begin
                            result_label <= 8'hFF;
                            done         <= 1'b1;
                            state        <= S_DONE;
                        end
                    end
                end
                S_CLEAR: begin
                    mem_en   <= 1'b1;
                    mem_addr <= {N_W{1'b0}};
                    state    <= S_STREAM;
                end
                S_STREAM: begin
                    if (mem_addr == n_reg - N_W'(1)) begin
                        mem_en <= 1'b0;
                        state  <= S_DRAIN;
                    end else begin
                        mem_addr <= mem_addr + N_W'(1);
                    end
                end
                S_DRAIN: begin
                    vote_idx   <= {M_W{1'b0}};
                    best_cnt   <= {M_W{1'b0}};
                    best_label <= 8'd0;
                    state      <= S_VOTE;
                end
                S_VOTE: begin
                    if (cur_wins_s) begin
                        best_cnt   <= cur_cnt_s;
                        best_label <= cur_label_s;
                    end
                    if (vote_idx == m_reg - M_W'(1)) begin
                        result_label <= cur_wins_s ? cur_label_s : best_label;
                        done         <= 1'b1;
                        state        <= S_DONE;
                    end else begin
                        vote_idx <= vote_idx + M_W'(1);
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy   <= 1'b0;
                    mem_en <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

`ifdef KNN_CTRL_CNT_EN
    // Busy-cycle counter: cleared on an accepted start, frozen once DONE is reached.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt <= 32'd0;
        end else if ((state == S_IDLE) && start) begin
            cycle_cnt <= 32'd0;
        end else if ((state != S_IDLE) && (state != S_DONE)) begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end
`else
    assign cycle_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_knn_ctrl.sv
// Testbench for knn_ctrl.
//
// The bench wraps the controller with two behavioural models:
//   - a training memory with one-cycle read latency,
//   - a nearest-neighbour core that does sorted insertion.
// Each classification result is compared against a reference computed
// directly from the training set: stable sort by distance, then a
// majority vote where the nearest slot wins ties.
module tb_knn_ctrl;

    localparam int K   = 10;
    localparam int N_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [N_W-1:0]   n_points;
    logic [15:0]      test_x;
    logic [15:0]      test_y;
    logic             mem_en;
    logic [N_W-1:0]   mem_addr;
    logic [39:0]      mem_rdata;
    logic             core_clr;
    logic             core_we;
    logic [15:0]      core_ax;
    logic [15:0]      core_ay;
    logic [15:0]      core_bx;
    logic [15:0]      core_by;
    logic [7:0]       core_label;
    logic [8*K-1:0]   core_labels;
    logic             busy;
    logic             done;
    logic [7:0]       result_label;
    logic [31:0]      cycle_cnt;

    int checks   = 0;
    int failures = 0;

    knn_ctrl #(.K(K), .N_W(N_W)) dut (
        .clk(clk), .rst(rst), .start(start), .n_points(n_points),
        .test_x(test_x), .test_y(test_y), .mem_en(mem_en), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .core_clr(core_clr), .core_we(core_we),
        .core_ax(core_ax), .core_ay(core_ay), .core_bx(core_bx), .core_by(core_by),
        .core_label(core_label), .core_labels(core_labels), .busy(busy),
        .done(done), .result_label(result_label), .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    // Training memory: one-cycle read latency.
    logic [39:0] mem [0:63];
    always @(posedge clk) begin
        if (mem_en) mem_rdata <= mem[mem_addr[5:0]];
    end

    function automatic longint sqdist(input logic [15:0] ax, ay, bx, by);
        longint dx, dy;
        dx = longint'(ax) - longint'(bx);
        dy = longint'(ay) - longint'(by);
        return dx * dx + dy * dy;
    endfunction

    // Core model: sorted neighbour list.
    // A new entry goes ahead of the first strictly larger distance.
    longint     cdist [K];
    logic [7:0] clab  [K];
    longint     new_d;
    int         pos_s;

    always_comb begin
        new_d = sqdist(core_ax, core_ay, core_bx, core_by);
        pos_s = K;
        for (int i = K - 1; i >= 0; i--) if (new_d < cdist[i]) pos_s = i;
        for (int i = 0; i < K; i++) core_labels[i*8 +: 8] = clab[i];
    end

    always @(posedge clk) begin
        if (core_clr) begin
            for (int i = 0; i < K; i++) begin
                cdist[i] <= 64'h7FFF_FFFF_FFFF_FFFF;
                clab[i]  <= 8'd0;
            end
        end else if (core_we) begin
            for (int i = 0; i < K; i++) begin
                if (i > 0 && i > pos_s) begin
                    cdist[i] <= cdist[(i > 0) ? i - 1 : 0];
                    clab[i]  <= clab[(i > 0) ? i - 1 : 0];
                end else if (i == pos_s) begin
                    cdist[i] <= new_d;
                    clab[i]  <= core_label;
                end
            end
        end
    end

    // Reference classification computed straight from the training set.
    function automatic logic [7:0] ref_label(input int n, input logic [15:0] tx, ty);
        longint     d     [64];
        bit         taken [64];
        logic [7:0] sl    [K];
        int         m, best, bc, c;
        logic [7:0] bl;
        if (n == 0) return 8'hFF;
        m = (n < K) ? n : K;
        for (int i = 0; i < n; i++) begin
            d[i]     = sqdist(tx, ty, mem[i][31:16], mem[i][15:0]);
            taken[i] = 1'b0;
        end
        for (int s = 0; s < m; s++) begin
            best = -1;
            for (int i = 0; i < n; i++)
                if (!taken[i] && (best < 0 || d[i] < d[best])) best = i;
            taken[best] = 1'b1;
            sl[s] = mem[best][39:32];
        end
        bc = 0;
        bl = 8'd0;
        for (int i = 0; i < m; i++) begin
            c = 0;
            for (int j = 0; j < m; j++) if (sl[j] == sl[i]) c++;
            if (c > bc) begin
                bc = c;
                bl = sl[i];
            end
        end
        return bl;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One classification request.
    // start_at >= 0 pulses an extra start during that cycle; it must be ignored.
    task automatic run(input int n, input logic [15:0] tx, ty,
                       input logic [7:0] exp_lbl, input int start_at);
        int m, exp_done, window, cyc, stream_cnt, we_cnt, done_cnt, done_cyc, clr_cnt;
        m        = (n < K) ? n : K;
        exp_done = (n == 0) ? 1 : n + m + 3;
        window   = 2 * exp_done + 4;
        stream_cnt = 0; we_cnt = 0; done_cnt = 0; done_cyc = -1; clr_cnt = 0;
        @(negedge clk);
        test_x = tx; test_y = ty; n_points = N_W'(n); start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        test_x = ~tx;
        test_y = ~ty;
        for (cyc = 1; cyc <= window; cyc++) begin
            check("busy", busy, (cyc <= exp_done));
            if (mem_en) begin
                check("mem_addr", mem_addr, stream_cnt);
                check("mem_en_window", (cyc >= 2 && cyc <= n + 1), 1'b1);
                stream_cnt++;
            end
            if (core_we) begin
                check("core_ax", core_ax, tx);
                check("core_ay", core_ay, ty);
                we_cnt++;
            end
            if (core_clr) begin
                check("core_clr_cycle", cyc, 1);
                clr_cnt++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("result_at_done", result_label, exp_lbl);
            end
            start = (cyc == start_at);
            @(negedge clk);
        end
        start = 1'b0;
        check("stream_count", stream_cnt, n);
        check("we_count", we_cnt, n);
        check("clr_count", clr_cnt, (n > 0) ? 1 : 0);
        check("done_count", done_cnt, 1);
        check("done_cycle", done_cyc, exp_done);
        check("result_hold", result_label, exp_lbl);
`ifdef KNN_CTRL_CNT_EN
        check("cycle_cnt", cycle_cnt, (n == 0) ? 0 : n + m + 2);
`else
        check("cycle_cnt", cycle_cnt, 0);
`endif
    endtask

    logic [15:0] rx, ry;
    int          rn;

    initial begin
        rst = 1'b1; start = 1'b0; n_points = '0; test_x = '0; test_y = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_mem_en", mem_en, 1'b0);
        check("rst_core_we", core_we, 1'b0);
        check("rst_core_clr", core_clr, 1'b0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_core_ax", core_ax, 0);
        check("rst_core_ay", core_ay, 0);
        check("rst_cycle_cnt", cycle_cnt, 0);
        check("rst_result", result_label, 8'hFF);
        rst = 1'b0;

        // Labels {5,5,7} at increasing distance: label 5 wins.
        mem[0] = {8'd5, 16'd1, 16'd0};
        mem[1] = {8'd5, 16'd2, 16'd0};
        mem[2] = {8'd7, 16'd3, 16'd0};
        run(3, 16'd0, 16'd0, 8'd5, -1);

        // Empty training set.
        run(0, 16'd0, 16'd0, 8'hFF, -1);

        // 5-5 tie among the nearest ten: slot 0's label (1) wins.
        for (int i = 0; i < 12; i++) mem[i] = {((i % 2) == 0) ? 8'd1 : 8'd2, 16'(i + 1), 16'd0};
        run(12, 16'd0, 16'd0, 8'd1, -1);

        // Start pulse in the first vote cycle must be ignored.
        run(12, 16'd0, 16'd0, 8'd1, 15);

        // Reset in the 4th stream cycle of a 20-point run.
        for (int i = 0; i < 20; i++) mem[i] = {8'd3, 16'(i * 7), 16'(i)};
        @(negedge clk);
        n_points = N_W'(20); test_x = 16'd9; test_y = 16'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst_mem_en", mem_en, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_mem_en", mem_en, 1'b0);
        check("mid_rst_result", result_label, 8'hFF);
        rst = 1'b0;
        run(20, 16'd100, 16'd0, ref_label(20, 16'd100, 16'd0), -1);

        // Randomised runs, including the K and K+1 boundaries.
        for (int t = 0; t < 8; t++) begin
            rn = (t == 0) ? 1 : (t == 1) ? K : (t == 2) ? K + 1 : $urandom_range(1, 15);
            for (int i = 0; i < rn; i++)
                mem[i] = {8'($urandom_range(1, 3)), 16'($urandom), 16'($urandom)};
            rx = 16'($urandom);
            ry = 16'($urandom);
            run(rn, rx, ry, ref_label(rn, rx, ry), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
